// File: rtl/seq_engine_pkg.sv
// seq_engine_pkg: mode encoding and divider sizing shared by the sequence engine.
package seq_engine_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FIB  = 2'd1;
    localparam logic [1:0] S_TIM  = 2'd2;

    // Wide enough to count to the longest period, (2^prog_w)*base_div cycles.
    function automatic int div_w(int base_div, int prog_w);
        return $clog2(base_div * (1 << prog_w) + 1);
    endfunction

endpackage

// File: rtl/seq_engine_if.sv
// seq_engine_if: command and result bundle of one sequence-engine channel.
interface seq_engine_if #(
    parameter int DATA_W = 16,
    parameter int PROG_W = 3
);
    logic              start_f;
    logic              start_t;
    logic              stop_f_t;
    logic              update;
    logic [PROG_W-1:0] prog;
    logic [DATA_W-1:0] value;
    logic              valid;
    logic              wrap;
    logic              parity;
    logic [1:0]        mode;
    logic [PROG_W-1:0] prog_q;

    modport master (
        output start_f, start_t, stop_f_t, update, prog,
        input  value, valid, wrap, parity, mode, prog_q
    );

    modport slave (
        input  start_f, start_t, stop_f_t, update, prog,
        output value, valid, wrap, parity, mode, prog_q
    );
endinterface

// File: rtl/seq_engine_tick_div.sv
// tick_div: one-cycle tick every (prog_q+1)*BASE_DIV cycles while enabled.
module tick_div
    import seq_engine_pkg::*;
#(
    parameter int BASE_DIV = 25_000_000,
    parameter int PROG_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [PROG_W-1:0] prog_q,
    output logic              tick
);
    localparam int W = div_w(BASE_DIV, PROG_W);

    logic [W-1:0] cnt_q, cnt_d, last;

    assign last  = (W'(prog_q) + W'(1)) * W'(BASE_DIV) - W'(1);
    assign tick  = en && !clr && cnt_q == last;
    assign cnt_d = (clr || !en || tick) ? '0 : cnt_q + W'(1);

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/seq_engine.sv
// seq_engine: Fibonacci / free-running counter generator at a programmable tick rate.
// Define SEQ_ENGINE_PARITY_EN to build the parity register; otherwise parity is tied to 0.
module seq_engine
    import seq_engine_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int PROG_W   = 3,
    parameter int BASE_DIV = 25_000_000
) (
    input logic        clk,
    input logic        rst,
    seq_engine_if.slave bus
);
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] value_q, value_d, next_q, next_d;
    logic              valid_q, valid_d, wrap_q, wrap_d;
    logic [PROG_W-1:0] prog_q, prog_d;
    logic [DATA_W:0]   sum;
    logic              tick, clr;

    assign sum    = {1'b0, value_q} + {1'b0, next_q};
    assign clr    = bus.stop_f_t | bus.start_f | bus.start_t | bus.update;
    assign prog_d = bus.update ? bus.prog : prog_q;

    tick_div #(.BASE_DIV(BASE_DIV), .PROG_W(PROG_W)) u_div (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (mode_q != S_IDLE),
        .prog_q (prog_q),
        .tick   (tick)
    );

    always_comb begin
        mode_d  = mode_q;
        value_d = value_q;
        next_d  = next_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (bus.stop_f_t) begin
            mode_d = S_IDLE;
        end else if (bus.start_f || bus.start_t) begin
            mode_d  = bus.start_f ? S_FIB : S_TIM;
            value_d = '0;
            next_d  = bus.start_f ? DATA_W'(1) : next_q;
            valid_d = 1'b1;
        end else if (tick && mode_q == S_FIB) begin
            // a carry out of the sum restarts the sequence instead of showing a truncated value
            valid_d = 1'b1;
            wrap_d  = sum[DATA_W];
            value_d = sum[DATA_W] ? '0 : next_q;
            next_d  = sum[DATA_W] ? DATA_W'(1) : sum[DATA_W-1:0];
        end else if (tick) begin
            valid_d = 1'b1;
            wrap_d  = &value_q;
            value_d = value_q + DATA_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mode_q  <= S_IDLE;
            value_q <= '0;
            next_q  <= DATA_W'(1);
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            prog_q  <= '0;
        end else begin
            mode_q  <= mode_d;
            value_q <= value_d;
            next_q  <= next_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            prog_q  <= prog_d;
        end

`ifdef SEQ_ENGINE_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) parity_q <= 1'b0;
        else     parity_q <= ^value_d;
    assign bus.parity = parity_q;
`else
    assign bus.parity = 1'b0;
`endif

    assign bus.value  = value_q;
    assign bus.valid  = valid_q;
    assign bus.wrap   = wrap_q;
    assign bus.mode   = mode_q;
    assign bus.prog_q = prog_q;
endmodule
